aes_decrypt_round_ctrl: RTL and testbench
=========================================

// Module: aes_decrypt_round_ctrl
// PURPOSE
// Sequences one AES-128 inverse cipher over the shared round datapath (inverse round unit + last-round unit).
// - Accepts a ciphertext block on a valid/ready handshake.
// - Performs the initial AddRoundKey itself, then issues NR rounds to the round units, highest key index first.
// - Returns the plaintext on a valid/ready handshake.
// - Owns the round counter and the key-store read index; round keys come from an external, combinationally read key store.
// PARAMETERS
// NR         10   number of rounds (round keys 0..NR)
// KIDX_W     4    width of key index, >= clog2(NR+1)
// PORTS
// clk             in   1       clock, all state on rising edge
// rst_n           in   1       asynchronous active-low reset
// in_valid        in   1       ciphertext offered
// in_ready        out  1       controller can accept (IDLE only)
// in_data         in   128     ciphertext block
// out_valid       out  1       plaintext available, held until accepted
// out_ready       in   1       consumer accepts plaintext
// out_data        out  128     plaintext block
// key_idx         out  KIDX_W  round-key index to key store
// key_in          in   128     round key for key_idx, same cycle
// rnd_valid       out  1       issue strobe to round unit (one cycle)
// rnd_last        out  1       1: route to last-round unit, 0: inverse round unit
// rnd_state       out  128     state presented to round unit, 0 when rnd_valid=0
// rnd_out         in   128     selected round unit registered result
// busy            out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset (async assert): FSM=IDLE, state_reg=0, rcnt=0.
//   Outputs at reset: in_ready=1, out_valid=0, out_data=0, rnd_valid=0, rnd_last=0, rnd_state=0, key_idx=NR, busy=0.
// - Reset deassertion mid-operation: the block restarts in IDLE. An in-flight block is discarded and no output is produced for it.
// - FSM states: IDLE, KEYADD, ISSUE, CAPTURE, DONE.
// - IDLE: in_ready=1. On in_valid&&in_ready: state_reg<=in_data, rcnt<=NR-1, next state KEYADD.
// - KEYADD: key_idx=NR; state_reg<=state_reg^key_in; next state ISSUE.
// - ISSUE: rnd_valid=1, rnd_state=state_reg, key_idx=rcnt, rnd_last=(rcnt==0); next state CAPTURE.
//   The round unit samples on this edge; key_in is only required valid during ISSUE.
// - CAPTURE: rnd_valid=0, rnd_state=0; state_reg<=rnd_out.
//   If rcnt==0, next state DONE; otherwise rcnt<=rcnt-1 and next state ISSUE.
//   The round units' out_valid is never used: it is sticky in the last-round unit, so completion is timed by the FSM only.
// - DONE: out_valid=1, out_data=state_reg. On out_ready, next state IDLE. out_data stays stable while out_valid && !out_ready.
// - in_ready is 0 in every state except IDLE, so there is no same-cycle accept in DONE.
//   in_valid while busy is ignored; no data is lost because the producer must hold it.
// - Latency: accept at edge T -> out_valid high from cycle T+2+2*NR (T+22 for NR=10).
//   Throughput: one block per 2*NR+3 cycles minimum.
// - key_idx outside KEYADD/ISSUE is held at NR. It never exceeds NR.
// - rnd_state is forced to 0 whenever rnd_valid=0, so no state leaks onto the shared bus.
// - rcnt wraps never: rcnt is decremented only when nonzero.
// - Simultaneous out_ready and in_valid in DONE: output completes, FSM goes to IDLE, and the input is accepted next cycle.
// STRUCTURE
// - aes_pkg (shared): localparam NR; typedef logic [127:0] aes_block_t; typedef enum {IDLE,KEYADD,ISSUE,CAPTURE,DONE} dec_ctrl_state_e.
// - No sub-module needed: the FSM, rcnt down-counter and 128-bit state_reg are inline.
//   The round units and key store stay outside; a top-level wrapper connects them.
// TESTING
// - FIPS-197 C.1: key 000102..0f expanded in key-store model, in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
//   -> out_data=00112233445566778899aabbccddeeff, out_valid exactly at T+22.
// - Key index trace for the same block: key_idx sequence over KEYADD/ISSUE = 10,9,8,...,1,0.
//   rnd_last=1 only in the final ISSUE; rnd_valid pulses exactly 10 times.
// - Backpressure: out_ready=0 for 5 cycles after out_valid.
//   -> out_data stable, in_ready=0, and a second in_valid is not accepted until one cycle after out_ready.
// - Back-to-back: two blocks, in_valid held high and out_ready=1.
//   -> second accept one cycle after first out handshake; both plaintexts correct.
// - Reset mid-block: rst_n low during the 4th ISSUE.
//   -> all outputs take their reset values immediately, no out_valid follows, and the next block decrypts correctly.
// - Bus hygiene: for every cycle with rnd_valid=0, check rnd_state==0. For all cycles, key_idx<=NR.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 decrypt round controller
package aes_pkg;

    localparam int NR     = 10;
    localparam int KIDX_W = 4;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [2:0] {
        IDLE,
        KEYADD,
        ISSUE,
        CAPTURE,
        DONE
    } dec_ctrl_state_e;

endpackage

// File: rtl/aes_decrypt_round_ctrl.sv
// rtl/aes_decrypt_round_ctrl.sv - sequences one AES-128 inverse cipher over external round units
module aes_decrypt_round_ctrl #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      key_in,
    output logic              rnd_valid,
    output logic              rnd_last,
    output logic [127:0]      rnd_state,
    input  logic [127:0]      rnd_out,
    output logic              busy
);
    import aes_pkg::*;

    dec_ctrl_state_e   st_q, st_d;
    aes_block_t        state_reg_q, state_reg_d;
    logic [KIDX_W-1:0] rcnt_q, rcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            state_reg_q <= '0;
            rcnt_q      <= '0;
        end else begin
            st_q        <= st_d;
            state_reg_q <= state_reg_d;
            rcnt_q      <= rcnt_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        state_reg_d = state_reg_q;
        rcnt_d      = rcnt_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        rnd_valid   = 1'b0;
        rnd_last    = 1'b0;
        rnd_state   = '0;
        key_idx     = KIDX_W'(NR);
        busy        = (st_q != IDLE);

        unique case (st_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_reg_d = in_data;
                    rcnt_d      = KIDX_W'(NR - 1);
                    st_d        = KEYADD;
                end
            end
            KEYADD: begin
                state_reg_d = state_reg_q ^ key_in;
                st_d        = ISSUE;
            end
            ISSUE: begin
                // Round unit registers rnd_state/key_in on the edge leaving this state.
                rnd_valid = 1'b1;
                rnd_state = state_reg_q;
                key_idx   = rcnt_q;
                rnd_last  = (rcnt_q == '0);
                st_d      = CAPTURE;
            end
            CAPTURE: begin
                // Round-unit valid is sticky, so the FSM alone decides when rnd_out is fresh.
                state_reg_d = rnd_out;
                if (rcnt_q == '0) begin
                    st_d = DONE;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                    st_d   = ISSUE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = state_reg_q;
                if (out_ready) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_round_ctrl.sv
// tb/tb_aes_decrypt_round_ctrl.sv - self-checking bench with AES round-unit and key-store models
module tb_aes_decrypt_round_ctrl;
    import aes_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_data;
    logic [KIDX_W-1:0] key_idx;
    logic [127:0]      key_in;
    logic              rnd_valid;
    logic              rnd_last;
    logic [127:0]      rnd_state;
    logic [127:0]      rnd_out = '0;
    logic              busy;

    always #5 clk = ~clk;

    aes_decrypt_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_idx(key_idx), .key_in(key_in),
        .rnd_valid(rnd_valid), .rnd_last(rnd_last), .rnd_state(rnd_state),
        .rnd_out(rnd_out), .busy(busy)
    );

    logic [7:0] sbox [256];
    logic [7:0] isbox[256];
    aes_block_t rk   [NR+1];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rv_cnt = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic aes_block_t inv_shift_sub(input aes_block_t s);
        aes_block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = isbox[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
        return o;
    endfunction

    function automatic aes_block_t inv_mix(input aes_block_t s);
        aes_block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
            o[119-32*c -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
            o[111-32*c -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
            o[103-32*c -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic aes_block_t inv_round(input aes_block_t s, input aes_block_t k);
        return inv_mix(inv_shift_sub(s) ^ k);
    endfunction

    function automatic aes_block_t last_round(input aes_block_t s, input aes_block_t k);
        return inv_shift_sub(s) ^ k;
    endfunction

    function automatic aes_block_t aes_dec(input aes_block_t ct);
        aes_block_t s = ct ^ rk[NR];
        for (int r = NR - 1; r >= 1; r--) s = inv_round(s, rk[r]);
        return last_round(s, rk[0]);
    endfunction

    task automatic build_tables();
        logic [7:0]  inv, b;
        logic [31:0] w[4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        aes_block_t  key = 128'h000102030405060708090a0b0c0d0e0f;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0],b[7]} ^ {b[5:0],b[7:6]} ^ {b[4:0],b[7:5]} ^ {b[3:0],b[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Key store (combinational) and the pair of round units sharing one registered output.
    always_comb key_in = (int'(key_idx) <= NR) ? rk[key_idx] : '0;

    always @(posedge clk)
        if (rnd_valid) rnd_out <= rnd_last ? last_round(rnd_state, key_in) : inv_round(rnd_state, key_in);

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        logic ok;
        @(posedge clk);
        #1;
        cyc++;
        ok = (rnd_valid || rnd_state == '0) && (int'(key_idx) <= NR) && (busy == !in_ready);
        check("bus_hygiene", 128'(ok), 128'd1);
        if (rnd_valid) rv_cnt++;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_ctl"}, {in_ready, out_valid, rnd_valid, rnd_last, busy}, 5'b10000);
        check({name, "_odata"}, out_data, '0);
        check({name, "_rstate"}, rnd_state, '0);
        check({name, "_kidx"}, key_idx, NR);
    endtask

    task automatic run_block(input aes_block_t ct, input aes_block_t exp, input int hold);
        int n;
        int lat;
        logic trace_ok;
        logic [KIDX_W-1:0] issued[$];
        logic lasts[$];
        in_data  = ct;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        check("keyadd_idx", {rnd_valid, key_idx}, {1'b0, KIDX_W'(NR)});
        rv_cnt = 0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
            if (rnd_valid) begin
                issued.push_back(key_idx);
                lasts.push_back(rnd_last);
            end
        end
        check("latency", lat, 2 + 2*NR);
        check("plaintext", out_data, exp);
        check("rnd_pulses", rv_cnt, NR);
        trace_ok = (issued.size() == NR);
        for (int i = 0; i < issued.size(); i++)
            if (int'(issued[i]) != NR - 1 - i || lasts[i] != (i == NR - 1)) trace_ok = 1'b0;
        check("key_trace", 128'(trace_ok), 128'd1);
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_data", out_data, exp);
                check("hold_ctl", {out_valid, in_ready}, 2'b10);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after_out", {out_valid, in_ready}, 2'b01);
        in_valid = 1'b0;
    endtask

    typedef struct {
        aes_block_t ct;
        aes_block_t pt;
        int         hold;
    } vec_t;

    localparam aes_block_t FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_block_t FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        vec_t tbl[6];
        aes_block_t ct1, ct2;
        int acc[$];
        int outh[$];
        aes_block_t got[$];
        logic bad;
        int n;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        build_tables();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;
        step();
        check_reset_outs("idle");

        tbl[0] = '{FIPS_CT, FIPS_PT, 0};
        for (int i = 1; i < 6; i++) begin
            tbl[i].ct   = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].pt   = aes_dec(tbl[i].ct);
            tbl[i].hold = (i == 1) ? 5 : int'($urandom_range(0, 3));
        end
        for (int i = 0; i < 6; i++) run_block(tbl[i].ct, tbl[i].pt, tbl[i].hold);

        // Back-to-back: producer keeps in_valid high, consumer always ready.
        ct1 = {$urandom, $urandom, $urandom, $urandom};
        ct2 = {$urandom, $urandom, $urandom, $urandom};
        in_data = ct1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 80 && got.size() < 2; i++) begin
            if (in_valid && in_ready) acc.push_back(cyc);
            if (out_valid && out_ready) begin
                outh.push_back(cyc);
                got.push_back(out_data);
            end
            step();
            if (acc.size() == 1) in_data = ct2;
            if (acc.size() >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count", got.size(), 2);
        if (got.size() == 2 && acc.size() == 2) begin
            check("b2b_pt0", got[0], aes_dec(ct1));
            check("b2b_pt1", got[1], aes_dec(ct2));
            check("b2b_accept_gap", acc[1], outh[0] + 1);
        end
        step();

        // Reset asserted asynchronously during the 4th ISSUE.
        in_data = FIPS_CT; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        step();
        in_valid = 1'b0;
        rv_cnt = 0;
        n = 0;
        while (rv_cnt < 4 && n < 40) begin step(); n++; end
        check("reach_4th_issue", {rnd_valid, key_idx}, {1'b1, KIDX_W'(NR - 4)});
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        check("no_out_after_rst", 128'(bad), 128'd0);
        run_block(FIPS_CT, FIPS_PT, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
